play_stream_engine: RTL

PLAY_STREAM_ENGINE -- requirements
Module: play_stream_engine

---
 rtl/play_stream_if.sv | 35 +++
 rtl/play_stream_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/play_stream_if.sv
// Control, SDRAM-read and audio-stream signals of play_stream_engine.
// master = the engine, slave = its environment.
interface play_stream_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              play_start;
  logic [ADDR_W-1:0] play_select;
  logic              play_pause;
  logic              play_stop;
  logic              play_loop;
  logic              play_done;
  logic              play_busy;
  logic              play_read;
  logic [ADDR_W-1:0] play_addr;
  logic [DATA_W-1:0] play_readdata;
  logic              play_sdram_finished;
  logic              play_audio_valid;
  logic [DATA_W-1:0] play_audio_data;
  logic              play_audio_ready;

  modport master (
    input  play_start, play_select, play_pause, play_stop, play_loop,
           play_readdata, play_sdram_finished, play_audio_ready,
    output play_done, play_busy, play_read, play_addr,
           play_audio_valid, play_audio_data
  );

  modport slave (
    output play_start, play_select, play_pause, play_stop, play_loop,
           play_readdata, play_sdram_finished, play_audio_ready,
    input  play_done, play_busy, play_read, play_addr,
           play_audio_valid, play_audio_data
  );
endinterface

// File: rtl/play_stream_engine.sv
// Streams a length-prefixed clip from SDRAM through a prefetch FIFO to audio.
// Optional clip repeat is enabled by defining PLAY_STREAM_LOOP_EN.
module play_stream_engine #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  play_stream_if.master     bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_FETCH, S_DRAIN, S_ABORT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, end_q, end_d, addr_q, addr_d;
  logic              read_q, read_d, done_q, done_d, hold_q, hold_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              push, pop, flush, fifo_empty, loop_hit, audio_valid;
  logic [ADDR_W-1:0] hdr_len;

`ifdef PLAY_STREAM_LOOP_EN
  assign loop_hit = bus.play_loop;
`else
  logic unused_loop;
  assign unused_loop = bus.play_loop;
  assign loop_hit    = 1'b0;
`endif

  assign fifo_empty  = (count_q == '0);
  assign hdr_len     = bus.play_readdata[ADDR_W-1:0];
  // hold_q keeps an offered word on the bus through a pause until it is taken
  assign audio_valid = !fifo_empty && (!bus.play_pause || hold_q);
  assign pop         = audio_valid && bus.play_audio_ready;

  assign bus.play_audio_valid = audio_valid;
  assign bus.play_audio_data  = audio_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.play_read        = read_q;
  assign bus.play_addr        = addr_q;
  assign bus.play_done        = done_q;
  assign bus.play_busy        = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    end_d   = end_q;
    addr_d  = addr_q;
    read_d  = read_q;
    done_d  = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.play_start) begin
          base_d  = bus.play_select;
          addr_d  = bus.play_select;
          read_d  = 1'b1;
          state_d = S_HDR;
        end
      end
      S_HDR, S_FETCH, S_DRAIN: begin
        if (bus.play_stop) begin
          flush = 1'b1;
          if (read_q && !bus.play_sdram_finished) begin
            state_d = S_ABORT;
          end else begin
            read_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (state_q == S_HDR) begin
          if (bus.play_sdram_finished) begin
            read_d = 1'b0;
            if (hdr_len == '0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              end_d   = base_q + hdr_len;
              addr_d  = base_q + ADR_ONE;
              state_d = S_FETCH;
            end
          end
        end else if (state_q == S_FETCH) begin
          if (read_q) begin
            if (bus.play_sdram_finished) begin
              push   = 1'b1;
              read_d = 1'b0;
              addr_d = addr_q + ADR_ONE;
              if (addr_q == end_q) begin
                if (loop_hit) addr_d  = base_q + ADR_ONE;
                else          state_d = S_DRAIN;
              end
            end
          end else if (count_q < DEPTH_C && !bus.play_pause) begin
            read_d = 1'b1;
          end
        end else if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        if (bus.play_sdram_finished) begin
          read_d  = 1'b0;
          flush   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = audio_valid && !bus.play_audio_ready;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      hold_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      end_q    <= '0;
      addr_q   <= '0;
      read_q   <= 1'b0;
      done_q   <= 1'b0;
      hold_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      end_q    <= end_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      done_q   <= done_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the audio data output is gated by valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.play_readdata;
  end

endmodule
